hilo_muldiv_unit: RTL

//  Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO pair.
//  - Write side: EX-stage start/ack handshake for mult, div, mthi and mtlo.
//  - Read side: mfhi/mflo read port with an interlock STALL while an operation is in flight.
//  - Sits beside the pipeline ALU, which keeps single-cycle ops only.

---
 rtl/hilo_pkg.sv | 26 ++
 rtl/hilo_muldiv_unit_if.sv | 29 ++
 rtl/muldiv_iter_core.sv | 44 ++++
 rtl/hilo_muldiv_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encodings and the default datapath width.
// The divider datapath is compiled in only when HILO_DIV_EN is defined.
package hilo_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/ack and mfhi/mflo read bundle between the EX stage (master)
// and the HI/LO multiply/divide unit (slave).
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             start_ack;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, rd_en, rd_sel,
        input  start_ack, busy, done, rd_data, stall, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, rd_en, rd_sel,
        output start_ack, busy, done, rd_data, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_core.sv
// One combinational iteration of the shared multiply/divide datapath.
// Multiply: radix-2 shift-add on {hi,lo}, multiplier consumed from lo[0].
// Divide (HILO_DIV_EN only): restoring shift-subtract, remainder in hi,
// quotient bits shifted into lo.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    logic [WIDTH:0] sum;
`ifdef HILO_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
`endif

    // Select the multiply step, overridden by the divide step when dividing.
    always_comb begin
        sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        hi_out = sum[WIDTH:1];
        lo_out = {sum[0], lo_in[WIDTH-1:1]};
`ifdef HILO_DIV_EN
        shifted = {hi_in, lo_in[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (shifted >= {1'b0, opnd}) begin
                hi_out = diff;
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shifted[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO pair.
// Operands are latched as magnitudes at accept; sign fix-up is applied when
// the final iteration writes HI/LO. Define HILO_DIV_EN to build the divider;
// otherwise DIV/DIVU are acknowledged as no-ops.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input logic               clk,
    input logic               rst,
    hilo_muldiv_unit_if.slave bus
);
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_e           state_reg;
    state_e           state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] acc_hi_reg;
    logic [WIDTH-1:0] acc_lo_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             neg_reg;      // negate product (mult) or quotient (div)
`ifdef HILO_DIV_EN
    logic             is_div_reg;
    logic             neg_rem_reg;  // remainder follows the dividend sign
    logic             div_zero;
`endif

    logic             busy;
    logic             done;
    logic             accept;
    logic             iter_op;
    logic             signed_op;
    logic             sign_diff;
    op_e              op_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             core_is_div;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign op_q      = op_e'(bus.op);
    assign accept    = bus.start & ~busy;
    assign signed_op = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign sign_diff = bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
    assign mag_a     = (signed_op && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    assign mag_b     = (signed_op && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

`ifdef HILO_DIV_EN
    assign div_zero    = (bus.src_b == '0);
    assign iter_op     = (op_q == OP_MULT) || (op_q == OP_MULTU) ||
                         (op_q == OP_DIV)  || (op_q == OP_DIVU);
    assign core_is_div = is_div_reg;
`else
    assign iter_op     = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign core_is_div = 1'b0;
`endif

    muldiv_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .is_div (core_is_div),
        .hi_in  (acc_hi_reg),
        .lo_in  (acc_lo_reg),
        .opnd   (opnd_reg),
        .hi_out (core_hi),
        .lo_out (core_lo)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: a new request may be taken in IDLE or in the DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_FIN: state_next = (accept && iter_op) ? ST_RUN : ST_IDLE;
            ST_RUN:          if (cnt_reg == '0) state_next = ST_FIN;
            default:         state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: BUSY while iterating, DONE for the single FIN cycle.
    always_comb begin
        busy = (state_reg == ST_RUN);
        done = (state_reg == ST_FIN);
    end

    // Sign fix-up of the last iteration's result before it lands in HI/LO.
    always_comb begin
        {res_hi, res_lo} = neg_reg ? -{core_hi, core_lo} : {core_hi, core_lo};
`ifdef HILO_DIV_EN
        if (is_div_reg) begin
            res_lo = neg_reg     ? -core_lo : core_lo;
            res_hi = neg_rem_reg ? -core_hi : core_hi;
        end
`endif
    end

    // Datapath: latch operands on accept, iterate in RUN, commit on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg      <= HILO_RST;
            lo_reg      <= HILO_RST;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            opnd_reg    <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
`ifdef HILO_DIV_EN
            is_div_reg  <= 1'b0;
            neg_rem_reg <= 1'b0;
`endif
        end else if (accept) begin
            case (op_q)
                OP_MTHI: hi_reg <= bus.src_a;
                OP_MTLO: lo_reg <= bus.src_a;
                OP_MULT, OP_MULTU: begin
                    acc_hi_reg <= '0;
                    acc_lo_reg <= mag_b;
                    opnd_reg   <= mag_a;
                    neg_reg    <= signed_op & sign_diff;
                    cnt_reg    <= CNT_LOAD;
`ifdef HILO_DIV_EN
                    is_div_reg <= 1'b0;
`endif
                end
`ifdef HILO_DIV_EN
                OP_DIV, OP_DIVU: begin
                    // A zero divisor with the raw dividend yields quotient
                    // all-ones and remainder = dividend with no fix-up.
                    acc_hi_reg  <= '0;
                    acc_lo_reg  <= div_zero ? bus.src_a : mag_a;
                    opnd_reg    <= mag_b;
                    neg_reg     <= signed_op & ~div_zero & sign_diff;
                    neg_rem_reg <= signed_op & ~div_zero & bus.src_a[WIDTH-1];
                    is_div_reg  <= 1'b1;
                    cnt_reg     <= CNT_LOAD;
                end
`endif
                default: ;
            endcase
        end else if (busy) begin
            acc_hi_reg <= core_hi;
            acc_lo_reg <= core_lo;
            cnt_reg    <= cnt_reg - CW'(1);
            if (cnt_reg == '0) begin
                hi_reg <= res_hi;
                lo_reg <= res_lo;
            end
        end
    end

    assign bus.start_ack = accept;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_data   = bus.rd_sel ? hi_reg : lo_reg;
    assign bus.stall     = bus.rd_en & busy;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;

endmodule
